uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver. It captures each completed byte flagged by the receiver's done pulse, which comes from the baud-tick domain. Bytes are held in a first-word-fall-through FIFO that the APB slave logic drains. The block also reports fill level, full/empty status, a sticky overrun flag and a level-threshold interrupt.

## Interface
- `DATA_WIDTH`, default 8: width of each stored byte; matches the receiver data output.
- `DEPTH`, default 8: number of entries; must be a power of 2, minimum 2.
- `THRESHOLD`, default 4: `rx_irq` asserts while `count >= THRESHOLD`; legal range 1..DEPTH.
- `clk`, in, 1: system/APB clock; all state updates on its rising edge.
- `rst_n`, in, 1: synchronous, active-low reset, sampled on rising `clk`.
- `rx_dataIn`, in, DATA_WIDTH: byte from the receiver; stable from the done pulse until the next frame completes.
- `rx_doneTick`, in, 1: receiver done pulse; asynchronous to `clk`; treated as level-to-edge.
- `rd_en`, in, 1: pop request from the APB read of the RX data register.
- `rd_data`, out, DATA_WIDTH: head entry, first-word-fall-through; valid while `empty` = 0.
- `empty`, out, 1: FIFO holds zero entries.
- `full`, out, 1: FIFO holds DEPTH entries.
- `count`, out, $clog2(DEPTH)+1: current number of entries.
- `overrun`, out, 1: sticky; a byte was dropped because the FIFO was full.
- `clr_overrun`, in, 1: single-cycle clear of `overrun`.
- `rx_irq`, out, 1: level interrupt, `count >= THRESHOLD`.

## Operation
- Capture path: `rx_doneTick` passes through a 2-flop synchronizer (`sync1`, `sync2`) and then a delay flop `sync3`. `wr_req = sync2 & ~sync3`, which gives exactly one write per low-to-high transition, whatever the pulse width in `clk` cycles. On `wr_req`, `rx_dataIn` is sampled directly; it is stable by then.
- Storage: DEPTH x DATA_WIDTH register array, `wr_ptr` and `rd_ptr` of $clog2(DEPTH) bits. Each pointer wraps from DEPTH-1 to 0 by natural overflow. `count` is tracked separately, so full and empty are never ambiguous.
- Write (`wr_req`, not full): `mem[wr_ptr] <= rx_dataIn`, `wr_ptr` increments, `count` increments.
- Write when full with no pop: the byte is discarded. Pointers and count are unchanged and `overrun` is set.
- Pop (`rd_en`, not empty): `rd_ptr` increments and `count` decrements. `rd_en` while empty is ignored and has no side effects.
- Simultaneous `wr_req` and `rd_en`:
  - Not empty: both happen, `count` is unchanged.
  - Full: both happen, no overrun.
  - Empty: only the write happens.
- `overrun`: set has priority over `clr_overrun` in the same cycle. It stays set until it is cleared or reset.
- `rd_data = mem[rd_ptr]` is combinational from the array. Its value is don't-care while empty; the bench must not check it then.
- Flags are combinational from `count`:
  - `empty = (count == 0)`
  - `full = (count == DEPTH)`
  - `rx_irq = (count >= THRESHOLD)`
- Reset (`rst_n` = 0 at a rising edge):
  - `wr_ptr`, `rd_ptr`, `count` = 0 and `overrun` = 0.
  - Synchronizer flops = 0.
  - Array contents are not reset.
  - After reset: `empty` = 1, `full` = 0, `rx_irq` = 0, `count` = 0.
  - Reset mid-operation discards all entries. A done pulse still high when reset releases produces one write once `sync2` rises, because `sync3` restarts at 0.

## Timing
- Done pulse rising before edge N: `sync1` = 1 at N, `sync2` at N+1, `wr_req` high during the cycle after N+1. The byte is written at edge N+2 and `count`, `empty` and `rd_data` update after N+2. Latency is 3 `clk` edges.
- Pop: `rd_en` high at edge M; `rd_data` shows the next entry and `count` drops after M. There is zero-cycle read latency for the head entry.
- A done pulse shorter than one `clk` period is not guaranteed to be captured. The system requires `clk` at least 2x the `s_tick` frequency, and the receiver holds the done level at least one `clk` period.
- Back-to-back frames are at least 10 bit-times apart, so `wr_req` never fires on consecutive cycles.

## Test plan
- Reset then idle: `count` = 0, `empty` = 1, `full` = 0, `overrun` = 0, `rx_irq` = 0. Pulsing `rd_en` leaves all of them unchanged.
- Single byte: `rx_dataIn` = 0xA5 with a 1-`clk`-wide done pulse. After exactly 3 edges, `empty` = 0, `count` = 1, `rd_data` = 0xA5. `rd_en` for one cycle returns `empty` = 1.
- Ordering and wrap: write 0x01..0x0C interleaved with pops, so the pointers wrap at least once. Pops return 0x01..0x0C in order, and `count` matches the model every cycle.
- Threshold and full: 4 writes raise `rx_irq`. After 8 writes, `full` = 1 and `count` = 8. A 9th write of 0xFF leaves `count` = 8 and sets `overrun` = 1. Draining returns the first 8 bytes, with no 0xFF.
- Overrun clear and priority: assert `clr_overrun` in the same cycle as a full-drop `wr_req`, and `overrun` stays 1. Assert `clr_overrun` alone on the next cycle, and `overrun` = 0.
- Simultaneous and reset cases:
  - At `full`, align `wr_req` with `rd_en`: `count` stays 8, `overrun` stays 0, and the new byte appears last.
  - Assert `rst_n` = 0 with 5 entries held: `count` = 0 and `empty` = 1 on the next edge.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT FIFO behind the UART receiver. It captures a byte on each rising
// edge of the done level, once synchronized. It also reports level, full/empty, a sticky overrun and a threshold irq.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int THRESHOLD  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    rx_dataIn,
  input  logic                     rx_doneTick,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  input  logic                     clr_overrun,
  output logic                     rx_irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic                  sync1, sync2, sync3;
  logic                  wr_req, do_wr, do_rd;

  // sync3 lags sync2 so a long done level still yields a single write
  assign wr_req = sync2 & ~sync3;
  assign do_rd  = rd_en & ~empty;
  assign do_wr  = wr_req & (~full | rd_en);

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign rx_irq  = (count >= CW'(THRESHOLD));
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync3   <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      sync1 <= rx_doneTick;
      sync2 <= sync1;
      sync3 <= sync2;
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // a dropped byte wins over a clear in the same cycle
      if (wr_req && full && !rd_en) overrun <= 1'b1;
      else if (clr_overrun)         overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= rx_dataIn;
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: an op table with hand-computed expectations plus
// hand-written latency, overrun-priority and reset sequences.
module tb_uart_rx_fifo;
  logic       clk = 1'b0;
  logic       rst_n, rx_doneTick, rd_en, clr_overrun;
  logic [7:0] rx_dataIn, rd_data;
  logic       empty, full, overrun, rx_irq;
  logic [3:0] count;

  int errors = 0;
  int checks = 0;

  uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(8), .THRESHOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .rx_dataIn(rx_dataIn), .rx_doneTick(rx_doneTick),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full), .count(count),
    .overrun(overrun), .clr_overrun(clr_overrun), .rx_irq(rx_irq)
  );

  always #5 clk = ~clk;

  typedef enum int {OP_WR, OP_RD, OP_WRRD, OP_WRCLR, OP_CLR} op_e;
  typedef struct {
    op_e        op;
    logic [7:0] d;
    int         cnt;
    bit         irq;
    bit         ovr;
    logic [7:0] head;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(op_e op, logic [7:0] d, int cnt, bit irq, bit ovr, logic [7:0] head);
    vec_t v;
    v.op = op; v.d = d; v.cnt = cnt; v.irq = irq; v.ovr = ovr; v.head = head;
    tbl.push_back(v);
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_state(string nm, int idx, int cnt, bit irq, bit ovr);
    chk({nm, ".count"}, idx, 32'(count), 32'(cnt));
    chk({nm, ".empty"}, idx, 32'(empty), 32'(cnt == 0));
    chk({nm, ".full"}, idx, 32'(full), 32'(cnt == 8));
    chk({nm, ".irq"}, idx, 32'(rx_irq), 32'(irq));
    chk({nm, ".ovr"}, idx, 32'(overrun), 32'(ovr));
  endtask

  // Inputs change on negedge; done rises before edge N, write lands at edge N+2.
  // extra selects a side signal held high across edge N+2.
  task automatic wr_byte(logic [7:0] b, int extra);
    rx_dataIn = b; rx_doneTick = 1'b1;
    @(negedge clk); rx_doneTick = 1'b0;
    @(negedge clk);
    if (extra == 1) rd_en = 1'b1;
    if (extra == 2) clr_overrun = 1'b1;
    @(negedge clk);
    rd_en = 1'b0; clr_overrun = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rx_doneTick = 1'b0; rd_en = 1'b0; clr_overrun = 1'b0; rx_dataIn = 8'h00;

    // ordering and pointer wrap with interleaved pops
    add(OP_WR, 8'h01, 1, 0, 0, 8'h01); add(OP_WR, 8'h02, 2, 0, 0, 8'h01);
    add(OP_WR, 8'h03, 3, 0, 0, 8'h01);
    add(OP_RD, 8'h00, 2, 0, 0, 8'h02); add(OP_RD, 8'h00, 1, 0, 0, 8'h03);
    for (int i = 4; i <= 9; i++) add(OP_WR, 8'(i), i - 2, (i - 2) >= 4, 0, 8'h03);
    add(OP_RD, 8'h00, 6, 1, 0, 8'h04); add(OP_RD, 8'h00, 5, 1, 0, 8'h05);
    add(OP_RD, 8'h00, 4, 1, 0, 8'h06); add(OP_RD, 8'h00, 3, 0, 0, 8'h07);
    add(OP_WR, 8'h0A, 4, 1, 0, 8'h07); add(OP_WR, 8'h0B, 5, 1, 0, 8'h07);
    add(OP_WR, 8'h0C, 6, 1, 0, 8'h07);
    add(OP_RD, 8'h00, 5, 1, 0, 8'h08); add(OP_RD, 8'h00, 4, 1, 0, 8'h09);
    add(OP_RD, 8'h00, 3, 0, 0, 8'h0A); add(OP_RD, 8'h00, 2, 0, 0, 8'h0B);
    add(OP_RD, 8'h00, 1, 0, 0, 8'h0C); add(OP_RD, 8'h00, 0, 0, 0, 8'h00);
    add(OP_RD, 8'h00, 0, 0, 0, 8'h00);
    // threshold, full, overrun drop, clear priority, drain without the dropped bytes
    for (int i = 0; i < 8; i++) add(OP_WR, 8'h10 + 8'(i), i + 1, (i + 1) >= 4, 0, 8'h10);
    add(OP_WR, 8'hFF, 8, 1, 1, 8'h10);
    add(OP_WRCLR, 8'hFE, 8, 1, 1, 8'h10);
    add(OP_CLR, 8'h00, 8, 1, 0, 8'h10);
    for (int i = 1; i <= 8; i++) add(OP_RD, 8'h00, 8 - i, (8 - i) >= 4, 0, 8'h10 + 8'(i));
    // write aligned with pop at full: no overrun, new byte goes last
    for (int i = 0; i < 8; i++) add(OP_WR, 8'h20 + 8'(i), i + 1, (i + 1) >= 4, 0, 8'h20);
    add(OP_WRRD, 8'h28, 8, 1, 0, 8'h21);
    for (int i = 1; i <= 8; i++) add(OP_RD, 8'h00, 8 - i, (8 - i) >= 4, 0, 8'h21 + 8'(i));

    // reset state, and rd_en while empty has no effect
    @(negedge clk); @(negedge clk);
    chk_state("reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    pop(); pop();
    chk_state("idle_rd", 0, 0, 0, 0);

    // single byte: exactly 3 edges of latency, then one pop empties
    rx_dataIn = 8'hA5; rx_doneTick = 1'b1;
    @(negedge clk); rx_doneTick = 1'b0;
    @(negedge clk);
    chk("lat.count_at_2", 0, 32'(count), 32'd0);
    @(negedge clk);
    chk("lat.count_at_3", 0, 32'(count), 32'd1);
    chk("lat.empty", 0, 32'(empty), 32'd0);
    chk("lat.rd_data", 0, 32'(rd_data), 32'hA5);
    pop();
    chk("lat.empty_after_pop", 0, 32'(empty), 32'd1);

    // table
    foreach (tbl[k]) begin
      case (tbl[k].op)
        OP_WR:    wr_byte(tbl[k].d, 0);
        OP_WRRD:  wr_byte(tbl[k].d, 1);
        OP_WRCLR: wr_byte(tbl[k].d, 2);
        OP_RD:    pop();
        OP_CLR:   begin clr_overrun = 1'b1; @(negedge clk); clr_overrun = 1'b0; end
        default:  @(negedge clk);
      endcase
      chk_state("tbl", k, tbl[k].cnt, tbl[k].irq, tbl[k].ovr);
      if (tbl[k].cnt != 0) chk("tbl.rd_data", k, 32'(rd_data), 32'(tbl[k].head));
    end

    // a done level held for several cycles writes once
    rx_dataIn = 8'h3C; rx_doneTick = 1'b1;
    repeat (6) @(negedge clk);
    rx_doneTick = 1'b0;
    repeat (3) @(negedge clk);
    chk("wide.count", 0, 32'(count), 32'd1);
    chk("wide.rd_data", 0, 32'(rd_data), 32'h3C);

    // reset mid-operation with 5 entries held
    for (int i = 0; i < 4; i++) wr_byte(8'h50 + 8'(i), 0);
    chk("prerst.count", 0, 32'(count), 32'd5);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst.count", 0, 32'(count), 32'd0);
    chk("midrst.empty", 0, 32'(empty), 32'd1);

    // done level high across reset release produces exactly one write
    rx_dataIn = 8'h77; rx_doneTick = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rstdone.count_at_2", 0, 32'(count), 32'd0);
    @(negedge clk);
    chk("rstdone.count_at_3", 0, 32'(count), 32'd1);
    chk("rstdone.rd_data", 0, 32'(rd_data), 32'h77);
    repeat (4) @(negedge clk);
    rx_doneTick = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstdone.count_final", 0, 32'(count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
